// File: rtl/spatz_pkg.sv
// Shared types and constants for the spatz VRF bank arbiter.
package spatz_pkg;

  localparam int unsigned NrVrfRequesters = 3;
  localparam int unsigned VrfAddrWidth    = 7;
  localparam int unsigned VrfDataWidth    = 64;
  localparam int unsigned VrfBeWidth      = VrfDataWidth / 8;

  typedef logic [VrfAddrWidth-1:0] vrf_addr_t;
  typedef logic [VrfDataWidth-1:0] vrf_data_t;
  typedef logic [VrfBeWidth-1:0]   vrf_be_t;

  typedef enum logic [1:0] {
    VFU_PORT   = 2'd0,
    VLSU_PORT  = 2'd1,
    VSLDU_PORT = 2'd2
  } vrf_port_e;

  // Index width that stays legal when there is only one requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spatz_rr_pick.sv
// Generic round-robin picker: first set request at or above the pointer, wrapping.
module spatz_rr_pick
  import spatz_pkg::*;
#(
  parameter int unsigned NrReq = NrVrfRequesters,
  localparam int unsigned IdxWidth = idx_width(NrReq)
) (
  input  logic [NrReq-1:0]    req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NrReq-1:0]    gnt_o,
  output logic [IdxWidth-1:0] idx_o
);

  // Scan from the pointer upward modulo NrReq; the first hit wins.
  always_comb begin
    logic        found;
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NrReq; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= NrReq) j = j - NrReq;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxWidth'(j);
      end
    end
  end

endmodule

// File: rtl/spatz_vrf_arbiter.sv
// Two-level (priority class, then round-robin) arbiter for one single-ported VRF bank.
module spatz_vrf_arbiter
  import spatz_pkg::*;
#(
  parameter int unsigned NrReq     = NrVrfRequesters,
  parameter int unsigned AddrWidth = VrfAddrWidth,
  parameter int unsigned DataWidth = VrfDataWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrReq-1:0]                    req_valid_i,
  output logic [NrReq-1:0]                    req_ready_o,
  input  logic [NrReq-1:0]                    req_prio_i,
  input  logic [NrReq-1:0][AddrWidth-1:0]     req_addr_i,
  input  logic [NrReq-1:0]                    req_we_i,
  input  logic [NrReq-1:0][DataWidth-1:0]     req_wdata_i,
  input  logic [NrReq-1:0][DataWidth/8-1:0]   req_wbe_i,
  output logic [NrReq-1:0]                    rsp_valid_o,
  output logic [DataWidth-1:0]                rsp_rdata_o,
  output logic                                vrf_req_o,
  output logic                                vrf_we_o,
  output logic [AddrWidth-1:0]                vrf_addr_o,
  output logic [DataWidth-1:0]                vrf_wdata_o,
  output logic [DataWidth/8-1:0]              vrf_wbe_o,
  input  logic [DataWidth-1:0]                vrf_rdata_i
);

  localparam int unsigned IdxWidth = idx_width(NrReq);

  logic [NrReq-1:0]    w_hi_mask;
  logic [NrReq-1:0]    w_mask;
  logic [NrReq-1:0]    w_gnt;
  logic [IdxWidth-1:0] w_idx;
  logic                w_any;
  logic [IdxWidth-1:0] r_rr_ptr;
  logic                r_rsp_pending;
  logic [IdxWidth-1:0] r_rsp_id;

  // High-priority requesters shadow the low class entirely when present.
  assign w_hi_mask = req_valid_i & req_prio_i;
  assign w_mask    = (|w_hi_mask) ? w_hi_mask : req_valid_i;
  assign w_any     = |req_valid_i;

  spatz_rr_pick #(
    .NrReq (NrReq)
  ) u_pick (
    .req_i (w_mask),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_gnt),
    .idx_o (w_idx)
  );

  assign req_ready_o = w_gnt;
  assign vrf_req_o   = w_any;
  assign rsp_rdata_o = vrf_rdata_i;

  // Bank drive muxed from the winner; zeroed when nobody requests.
  always_comb begin
    vrf_we_o    = 1'b0;
    vrf_addr_o  = '0;
    vrf_wdata_o = '0;
    vrf_wbe_o   = '0;
    if (w_any) begin
      vrf_we_o    = req_we_i[w_idx];
      vrf_addr_o  = req_addr_i[w_idx];
      vrf_wdata_o = req_wdata_i[w_idx];
      vrf_wbe_o   = req_wbe_i[w_idx];
    end
  end

  // Round-robin pointer; a single requester needs no state.
  if (NrReq == 1) begin : gen_ptr_const
    assign r_rr_ptr = '0;
  end else begin : gen_ptr_reg
    // Advance past the winner on any grant, hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rr_ptr <= '0;
      end else if (w_any) begin
        r_rr_ptr <= (32'(w_idx) == NrReq - 1) ? '0 : w_idx + IdxWidth'(1);
      end
    end
  end

  // Track the owner of the read that is in flight in the bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_pending <= 1'b0;
      r_rsp_id      <= '0;
    end else begin
      r_rsp_pending <= w_any & ~vrf_we_o;
      r_rsp_id      <= w_idx;
    end
  end

  // Steer the response strobe to the requester that issued the read.
  always_comb begin
    rsp_valid_o = '0;
    if (r_rsp_pending) rsp_valid_o[r_rsp_id] = 1'b1;
  end

  // A waiting requester must hold its request unchanged until granted.
  for (genvar i = 0; i < NrReq; i++) begin : gen_proto
    a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[i] && !req_ready_o[i]) |=>
        (req_valid_i[i] && $stable(req_addr_i[i]) && $stable(req_we_i[i]) &&
         $stable(req_wdata_i[i]) && $stable(req_wbe_i[i])));
  end

endmodule

// File: tb/tb_spatz_vrf_arbiter.sv
// Directed bench for spatz_vrf_arbiter with a bank model and a response scoreboard.
module tb_spatz_vrf_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       valid, ready, prio, we, rsp_valid;
  logic [2:0][6:0]  addr;
  logic [2:0][63:0] wdata;
  logic [2:0][7:0]  wbe;
  logic [63:0]      rsp_rdata, vrf_wdata, vrf_rdata;
  logic             vrf_req, vrf_we;
  logic [6:0]       vrf_addr;
  logic [7:0]       vrf_wbe;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  logic [63:0] mem [128];
  logic        bank_init = 1'b0;

  always #5 clk = ~clk;

  spatz_vrf_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .req_prio_i  (prio),
    .req_addr_i  (addr),
    .req_we_i    (we),
    .req_wdata_i (wdata),
    .req_wbe_i   (wbe),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .vrf_req_o   (vrf_req),
    .vrf_we_o    (vrf_we),
    .vrf_addr_o  (vrf_addr),
    .vrf_wdata_o (vrf_wdata),
    .vrf_wbe_o   (vrf_wbe),
    .vrf_rdata_i (vrf_rdata)
  );

  function automatic logic [63:0] pat(input logic [6:0] a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  // One-cycle-latency byte-enabled SRAM bank.
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int a = 0; a < 128; a++) mem[a] <= pat(7'(a));
      mem[0]    <= 64'h0;
      mem[5]    <= 64'hDEADBEEF_00000001;
      vrf_rdata <= 64'h0;
      bank_init <= 1'b1;
    end else if (vrf_req) begin
      if (vrf_we) begin
        for (int b = 0; b < 8; b++)
          if (vrf_wbe[b]) mem[vrf_addr][b*8 +: 8] <= vrf_wdata[b*8 +: 8];
      end else begin
        vrf_rdata <= mem[vrf_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [2:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

  // Settle, check the response due this cycle and the grant, then log any read.
  task automatic step(input logic [2:0] exp_rdy, input logic is_rd,
                      input logic [63:0] exp_data, input string tag);
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rspv"}, 64'(rsp_valid), 64'(3'b001 << e.id));
      chk({tag, "_rdata"}, rsp_rdata, e.data);
    end else begin
      chk({tag, "_rspv"}, 64'(rsp_valid), 64'd0);
    end
    chk({tag, "_rdy"}, 64'(ready), 64'(exp_rdy));
    if (is_rd) begin
      e.id   = oh_idx(exp_rdy);
      e.data = exp_data;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    valid = '0; prio = '0; we = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    addr = '0; wdata = '0; wbe = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rdy", 64'(ready), 64'd0);
    chk("reset_rspv", 64'(rsp_valid), 64'd0);
    chk("reset_vrf_req", 64'(vrf_req), 64'd0);
    chk("reset_vrf_addr", 64'(vrf_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single VLSU read of a preloaded word.
    valid = 3'b010; addr[1] = 7'h05;
    step(3'b010, 1'b1, 64'hDEADBEEF_00000001, "single");
    chk("single_addr", 64'(vrf_addr), 64'h05);
    chk("single_req", 64'(vrf_req), 64'd1);
    @(negedge clk);
    idle();
    step(3'b000, 1'b0, 64'h0, "single_rsp");
    @(negedge clk);

    // Full write followed by a read of the same word from another requester.
    valid = 3'b001; we[0] = 1'b1; addr[0] = 7'h10;
    wdata[0] = 64'h0123456789ABCDEF; wbe[0] = 8'hFF;
    step(3'b001, 1'b0, 64'h0, "wr");
    chk("wr_we", 64'(vrf_we), 64'd1);
    chk("wr_wdata", vrf_wdata, 64'h0123456789ABCDEF);
    @(negedge clk);
    idle(); valid = 3'b100; addr[2] = 7'h10;
    step(3'b100, 1'b1, 64'h0123456789ABCDEF, "rd_after_wr");
    @(negedge clk);
    idle();
    step(3'b000, 1'b0, 64'h0, "rd_after_wr_rsp");
    @(negedge clk);

    // Round-robin over three low-priority readers, pointer at 0.
    addr[0] = 7'h20; addr[1] = 7'h21; addr[2] = 7'h22;
    valid = 3'b111;
    step(3'b001, 1'b1, pat(7'h20), "rr0"); @(negedge clk);
    step(3'b010, 1'b1, pat(7'h21), "rr1"); @(negedge clk);
    step(3'b100, 1'b1, pat(7'h22), "rr2"); @(negedge clk);
    step(3'b001, 1'b1, pat(7'h20), "rr3"); @(negedge clk);
    valid = 3'b110;
    step(3'b010, 1'b1, pat(7'h21), "rr4"); @(negedge clk);
    valid = 3'b100;
    step(3'b100, 1'b1, pat(7'h22), "rr5"); @(negedge clk);
    idle();
    step(3'b000, 1'b0, 64'h0, "rr_drain"); @(negedge clk);

    // High-priority VFU writes shadow the low-priority readers.
    valid = 3'b111; prio = 3'b001; we = 3'b001;
    addr[0] = 7'h30; addr[1] = 7'h31; addr[2] = 7'h32;
    wdata[0] = 64'h5555_AAAA_5555_AAAA; wbe[0] = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step(3'b001, 1'b0, 64'h0, "prio_hi");
      chk("prio_we", 64'(vrf_we), 64'd1);
      @(negedge clk);
    end
    valid = 3'b110; prio = 3'b000; we = 3'b000;
    step(3'b010, 1'b1, pat(7'h31), "prio_lo1"); @(negedge clk);
    valid = 3'b100;
    step(3'b100, 1'b1, pat(7'h32), "prio_lo2"); @(negedge clk);
    idle();
    step(3'b000, 1'b0, 64'h0, "prio_drain"); @(negedge clk);

    // Partial write of the low half, then read back.
    valid = 3'b001; we[0] = 1'b1; addr[0] = 7'h00;
    wdata[0] = 64'hFFFFFFFF_FFFFFFFF; wbe[0] = 8'h0F;
    step(3'b001, 1'b0, 64'h0, "pwr");
    chk("pwr_wbe", 64'(vrf_wbe), 64'h0F);
    @(negedge clk);
    idle(); valid = 3'b010; addr[1] = 7'h00;
    step(3'b010, 1'b1, 64'h00000000_FFFFFFFF, "pwr_rd"); @(negedge clk);
    idle();
    step(3'b000, 1'b0, 64'h0, "pwr_drain"); @(negedge clk);

    // Reset in the cycle after a read grant discards the response.
    valid = 3'b010; addr[1] = 7'h05;
    step(3'b010, 1'b1, 64'hDEADBEEF_00000001, "rst_rd");
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    sb_q.delete();
    #1;
    chk("rst_rspv", 64'(rsp_valid), 64'd0);
    chk("rst_vrf_req", 64'(vrf_req), 64'd0);
    chk("rst_vrf_we", 64'(vrf_we), 64'd0);
    chk("rst_vrf_addr", 64'(vrf_addr), 64'd0);
    chk("rst_vrf_wbe", 64'(vrf_wbe), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    addr[0] = 7'h20; addr[1] = 7'h21; addr[2] = 7'h22;
    valid = 3'b111;
    step(3'b001, 1'b1, pat(7'h20), "post_rst0"); @(negedge clk);
    valid = 3'b110;
    step(3'b010, 1'b1, pat(7'h21), "post_rst1"); @(negedge clk);
    valid = 3'b100;
    step(3'b100, 1'b1, pat(7'h22), "post_rst2"); @(negedge clk);
    idle();
    step(3'b000, 1'b0, 64'h0, "post_rst_drain"); @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
